uart_instr_loader: RTL

Parametrised successor to the single-byte UART-to-processor instruction path. Pops bytes from the UART receive FIFO and assembles INSTR_BYTES bytes, little-endian, into one INSTR_W-bit instruction word. Buffers up to DEPTH words and presents them to the processor core over a valid/ready handshake. Sits between the UART terminal and the processor top.

---
 rtl/uart_loader_pkg.sv | 11 +
 rtl/sync_word_fifo.sv | 52 +++++
 rtl/uart_instr_loader.sv | 100 ++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared state type and default sizing for the UART instruction loader
package uart_loader_pkg;

    typedef enum logic {COLLECT, HOLD} state_t;

    localparam int DEF_BYTE_W      = 8;
    localparam int DEF_INSTR_BYTES = 2;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_TIMEOUT_CYC = 100000;

endpackage

// File: rtl/sync_word_fifo.sv
// sync_word_fifo: power-of-2 word FIFO with registered head word (0 when empty)
module sync_word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]    count_next;
    logic             do_push, do_pop;

    assign full       = count == CW'(DEPTH);
    assign empty      = count == '0;
    assign do_pop     = pop & !empty;
    assign do_push    = push & (!full | do_pop);
    assign rd_next    = rd_ptr + PW'(do_pop);
    assign count_next = count + CW'(do_push) - CW'(do_pop);

    // storage array, written at the tail
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    // pointers, occupancy and head register; a push into an emptying FIFO forwards din to the head
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_next;
            count  <= count_next;
            head   <= (count_next == '0) ? '0 : (do_push && wr_ptr == rd_next) ? din : mem[rd_next];
        end
    end

endmodule

// File: rtl/uart_instr_loader.sv
// uart_instr_loader: assembles UART bytes little-endian into instruction words and queues them
// for the core; define LOADER_TIMEOUT_EN to discard stale partial words after TIMEOUT_CYC idle cycles.
module uart_instr_loader
    import uart_loader_pkg::*;
#(
    parameter int BYTE_W      = DEF_BYTE_W,
    parameter int INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 clk_en,
    input  logic                                 clear,
    input  logic                                 rx_empty,
    input  logic [BYTE_W-1:0]                    rx_data,
    output logic                                 rd_uart,
    output logic [BYTE_W*INSTR_BYTES-1:0]        instr,
    output logic                                 instr_valid,
    input  logic                                 instr_ready,
    output logic [$clog2(DEPTH+1)-1:0]           word_count,
    output logic [$clog2(INSTR_BYTES+1)-1:0]     byte_idx,
    output logic                                 resync_err
);

    localparam int INSTR_W = BYTE_W * INSTR_BYTES;
    localparam int BI_W    = $clog2(INSTR_BYTES+1);

    state_t             state;
    logic [INSTR_W-1:0] asm_word;
    logic               full, empty, word_pop, word_push, last_byte, timeout;

    assign rd_uart     = clk_en & !rx_empty & !clear & (state == COLLECT);
    assign instr_valid = !empty;
    assign word_pop    = clk_en & instr_valid & instr_ready;
    assign word_push   = clk_en & !clear & (state == HOLD) & (!full | word_pop);
    assign last_byte   = byte_idx == BI_W'(INSTR_BYTES-1);

    sync_word_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clk_en & clear),
        .push    (word_push),
        .pop     (word_pop),
        .din     (asm_word),
        .full    (full),
        .empty   (empty),
        .count   (word_count),
        .head    (instr)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] idle_cnt;
    logic          idle;

    assign idle    = clk_en & !clear & (state == COLLECT) & (byte_idx != '0) & !rd_uart;
    assign timeout = idle & (idle_cnt == TW'(TIMEOUT_CYC-1));

    // idle counter for a stalled partial word; resync_err is a one-cycle pulse on discard
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt   <= '0;
            resync_err <= 1'b0;
        end else begin
            resync_err <= timeout;
            if (clk_en) idle_cnt <= (idle && !timeout) ? idle_cnt + TW'(1) : '0;
        end
    end
`else
    assign timeout    = 1'b0;
    assign resync_err = 1'b0;
`endif

    // COLLECT fills byte lanes; HOLD waits for FIFO room so no word is ever dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= COLLECT;
            byte_idx <= '0;
            asm_word <= '0;
        end else if (clk_en) begin
            if (clear) begin
                state    <= COLLECT;
                byte_idx <= '0;
                asm_word <= '0;
            end else if (timeout) begin
                byte_idx <= '0;
            end else if (state == COLLECT && rd_uart) begin
                for (int i = 0; i < INSTR_BYTES; i++)
                    if (byte_idx == BI_W'(i)) asm_word[i*BYTE_W +: BYTE_W] <= rx_data;
                state    <= last_byte ? HOLD : COLLECT;
                byte_idx <= last_byte ? '0 : byte_idx + BI_W'(1);
            end else if (state == HOLD && word_push) begin
                state <= COLLECT;
            end
        end
    end

endmodule
